// File: rtl/fifo_loader_pkg.sv
// Shared types and default geometry for the delay-buffer FIFO loader and its FIFO bank.
package fifo_loader_pkg;

  localparam int DEF_DIM   = 8;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_BITS  = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MOD up counter: counts 0..MOD-1 on inc, wrap flags the terminal value.
// Latency: count updates on the edge after inc; wrap is decoded from the current count.
// Backpressure: none; inc is an unconditional request, clr has priority over inc.
module wrap_counter #(
  parameter int MOD = 8,
  localparam int W = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap
);

  // Compare against MOD-1 so non-power-of-two moduli wrap correctly.
  assign wrap = (count == W'(MOD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_loader.sv
// Streams DIM*DEPTH words row-major into DIM delay FIFOs; optional zero pre-fill (FIFO_LOADER_ZERO_FLUSH_EN).
// Latency: handshake at edge N drives fifo_d/fifo_en in cycle N+1; done pulses with the final word's enable.
// Backpressure: in_ready depends only on state (high throughout LOAD); in_valid gaps just stall the counters.
module fifo_loader
  import fifo_loader_pkg::*;
#(
  parameter int DIM   = DEF_DIM,
  parameter int DEPTH = DEF_DEPTH,
  parameter int BITS  = DEF_BITS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] in_data,
  output logic [BITS-1:0] fifo_d,
  output logic [DIM-1:0]  fifo_en,
  output logic            busy,
  output logic            done
);

  localparam int COL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ROW_W = (DIM > 1) ? $clog2(DIM) : 1;

  state_t             state;
  logic               hs;
  logic               cnt_clr;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic               col_wrap;
  logic               row_wrap;
  logic               last_word;

  assign in_ready  = (state == ST_LOAD);
  assign busy      = (state != ST_IDLE);
  assign hs        = in_valid & in_ready;
  assign cnt_clr   = (state == ST_IDLE) & start;
  assign last_word = hs & row_wrap & (col == COL_W'(DEPTH - 1));

  wrap_counter #(.MOD(DEPTH)) u_col (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (hs),
    .count (col),
    .wrap  (col_wrap)
  );

  wrap_counter #(.MOD(DIM)) u_row (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (hs & col_wrap),
    .count (row),
    .wrap  (row_wrap)
  );

`ifdef FIFO_LOADER_ZERO_FLUSH_EN
  logic [COL_W-1:0] flush_cnt;
  logic             flush_wrap;
  logic             unused_flush_cnt;

  // Flush length equals DEPTH so every slot of every FIFO is shifted to zero.
  wrap_counter #(.MOD(DEPTH)) u_flush (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (state == ST_FLUSH),
    .count (flush_cnt),
    .wrap  (flush_wrap)
  );

  assign unused_flush_cnt = ^flush_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      fifo_d  <= '0;
      fifo_en <= '0;
      done    <= 1'b0;
    end else begin
      fifo_en <= '0;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
`ifdef FIFO_LOADER_ZERO_FLUSH_EN
            // Enable goes up together with the state so the flush spans exactly the FLUSH cycles.
            state   <= ST_FLUSH;
            fifo_d  <= '0;
            fifo_en <= '1;
`else
            state   <= ST_LOAD;
`endif
          end
        end
`ifdef FIFO_LOADER_ZERO_FLUSH_EN
        ST_FLUSH: begin
          fifo_d <= '0;
          if (flush_wrap) begin
            state <= ST_LOAD;
          end else begin
            fifo_en <= '1;
          end
        end
`endif
        ST_LOAD: begin
          if (hs) begin
            fifo_d  <= in_data;
            fifo_en <= DIM'(1) << row;
            if (last_word) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_loader.sv
// Randomized bench for fifo_loader against a word-index reference model (lane = k / DEPTH).
module tb_fifo_loader;

  localparam int DIM   = 8;
  localparam int DEPTH = 8;
  localparam int BITS  = 64;
  localparam int NW    = DIM * DEPTH;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] in_data;
  logic [BITS-1:0] fifo_d;
  logic [DIM-1:0]  fifo_en;
  logic            busy;
  logic            done;

  fifo_loader #(.DIM(DIM), .DEPTH(DEPTH), .BITS(BITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .fifo_d   (fifo_d),
    .fifo_en  (fifo_en),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a word index plus load/flush bookkeeping.
  bit              m_loading = 1'b0;
  int              m_k       = 0;
  int              m_flush   = 0;
  logic [BITS-1:0] m_d       = '0;
  logic [DIM-1:0]  m_en;
  bit              m_done;
  int              en_pulses   = 0;
  int              done_pulses = 0;

  task automatic check(input string tag, input logic [BITS-1:0] obs, input logic [BITS-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [BITS-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic step(input logic r, input logic s, input logic v, input logic [BITS-1:0] d);
    rst_n    = r;
    start    = s;
    in_valid = v;
    in_data  = d;
    m_en     = '0;
    m_done   = 1'b0;
    if (!r) begin
      m_loading = 1'b0;
      m_flush   = 0;
      m_k       = 0;
      m_d       = '0;
    end else if (m_flush > 0) begin
      m_flush--;
      if (m_flush > 0) begin
        m_en = '1;
        m_d  = '0;
      end else begin
        m_loading = 1'b1;
      end
    end else if (m_loading) begin
      if (v) begin
        m_en   = DIM'(1) << (m_k / DEPTH);
        m_d    = d;
        m_done = (m_k == NW - 1);
        m_k++;
        if (m_done) m_loading = 1'b0;
      end
    end else if (s) begin
      m_k = 0;
`ifdef FIFO_LOADER_ZERO_FLUSH_EN
      m_flush = DEPTH;
      m_en    = '1;
      m_d     = '0;
`else
      m_loading = 1'b1;
`endif
    end
    @(posedge clk);
    @(negedge clk);
    check("fifo_en",  BITS'(fifo_en), BITS'(m_en));
    check("fifo_d",   fifo_d, m_d);
    check("done",     BITS'(done), BITS'(m_done));
    check("busy",     BITS'(busy), BITS'(m_loading || m_flush > 0));
    check("in_ready", BITS'(in_ready), BITS'(m_loading));
    if ($countones(fifo_en) == 1) en_pulses++;
    if (done) done_pulses++;
  endtask

  // Feed words until the model says the load ended or stop_at words were taken.
  task automatic load(input int pct, input int stop_at, input bit seq, input bit noise_start);
    int guard = 0;
    while ((m_loading || m_flush > 0) && m_k < stop_at) begin
      logic            v;
      logic            s;
      logic [BITS-1:0] d;
      if (guard > 4000) begin
        check("load_timeout", 1, 0);
        break;
      end
      guard++;
      v = ($urandom_range(99) < pct);
      s = noise_start ? 1'($urandom_range(1)) : 1'b0;
      d = seq ? BITS'(m_k) : rnd64();
      step(1'b1, s, v, d);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset held with start and in_valid active.
    repeat (3) step(1'b0, 1'b1, 1'b1, rnd64());

    // in_valid while idle must not consume anything.
    repeat (4) step(1'b1, 1'b0, 1'b1, rnd64());

    // Full-rate load, data = word index.
    step(1'b1, 1'b1, 1'b0, '0);
    en_pulses   = 0;
    done_pulses = 0;
    load(100, NW, 1'b1, 1'b0);
    check("full_en_pulses", BITS'(en_pulses), BITS'(NW));
    check("full_done_pulses", BITS'(done_pulses), 1);

    // Start in the done cycle, then a bubbly load with start noise while busy.
    en_pulses   = 0;
    done_pulses = 0;
    step(1'b1, 1'b1, 1'b1, rnd64());
    load(50, NW, 1'b0, 1'b1);
    check("bubble_en_pulses", BITS'(en_pulses), BITS'(NW));
    check("bubble_done_pulses", BITS'(done_pulses), 1);

    // Abort after 20 words, then a fresh load must restart at FIFO 0.
    step(1'b1, 1'b1, 1'b0, '0);
    load(100, 20, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, rnd64());
    step(1'b1, 1'b0, 1'b1, rnd64());
    en_pulses   = 0;
    done_pulses = 0;
    step(1'b1, 1'b1, 1'b0, '0);
    load(70, NW, 1'b1, 1'b1);
    check("restart_en_pulses", BITS'(en_pulses), BITS'(NW));
    check("restart_done_pulses", BITS'(done_pulses), 1);

    repeat (3) step(1'b1, 1'b0, 1'b1, rnd64());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_loader.md
# fifo_loader

Upstream load stage for the delay-buffer FIFO bank. Accepts a stream of BITS-wide words from the host/memory side over a valid/ready handshake and distributes them row-major into DIM per-row delay FIFOs by driving a shared data bus and a one-hot per-FIFO enable. Signals completion once DIM×DEPTH words are loaded, so the array controller can start draining the FIFOs.

## Interface
- DIM, 8, number of downstream FIFOs (rows); ≥2
- DEPTH, 8, entries per downstream FIFO; ≥2
- BITS, 64, word width; equals downstream FIFO width
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  begin a load; sampled only in IDLE
- in_valid  input  1  upstream word valid
- in_ready  output  1  loader accepts word this cycle
- in_data  input  BITS  upstream word
- fifo_d  output  BITS  data to all downstream FIFO `d` inputs
- fifo_en  output  DIM  per-FIFO enable, at most one hot during LOAD
- busy  output  1  state ≠ IDLE
- done  output  1  one-cycle pulse, load complete

## Operation
- States: IDLE, FLUSH (macro only), LOAD.
- IDLE: in_ready=0, fifo_en=0. start=1 → LOAD (or FLUSH with macro); clear col and row counters.
- LOAD: in_ready=1. Handshake = in_valid & in_ready. On handshake: fifo_d ← in_data, fifo_en ← one-hot(row); col increments; col wraps DEPTH-1→0 and row increments. No handshake → fifo_en=0, fifo_d holds.
- Word k (0-based) lands in FIFO k/DEPTH, slot k%DEPTH.
- Handshake with row=DIM-1, col=DEPTH-1 → IDLE, done pulses.
- col width $clog2(DEPTH), row width $clog2(DIM); counters compare against DEPTH-1/DIM-1, not power-of-two wrap.
- start while busy: ignored. in_valid outside LOAD: ignored, no data consumed.
- rst_n=0 at any point, including mid-load: state IDLE, counters 0, fifo_en=0, fifo_d=0, done=0 on next edge; partially loaded data abandoned.

## Timing
- Reset values: in_ready=0, fifo_en=0, fifo_d=0, busy=0, done=0.
- fifo_d, fifo_en, done registered; in_ready decoded from state register only (no in_valid dependence).
- start high at edge S → busy and in_ready high from S+1 (no macro).
- Handshake at edge N → fifo_en/fifo_d valid for cycle N+1, consumed by FIFO at edge N+1.
- Final handshake at edge N → done=1 and final fifo_en in cycle N+1, busy=0 and in_ready=0 in cycle N+1.
- Back-to-back: full throughput, one word per cycle; minimum load time DIM×DEPTH cycles after LOAD entry.
- start asserted in the done cycle is accepted (state already IDLE).

## Configuration
- FIFO_LOADER_ZERO_FLUSH_EN defined: start → FLUSH for exactly DEPTH cycles; each cycle fifo_d=0, fifo_en=all ones, in_ready=0; then LOAD. Guarantees every FIFO slot is zero before loading regardless of history.
- Undefined: FLUSH state absent; start → LOAD directly.

## Structure
- fifo_loader_pkg: state enum type, default DIM/DEPTH/BITS localparams shared with the FIFO bank.
- One sub-module: wrap_counter (parameter MOD; inc input, count and wrap outputs), instantiated for col (MOD=DEPTH), row (MOD=DIM) and flush count.

## Test plan
- Reset: hold rst_n=0 3 cycles with in_valid=1, start=1 → all outputs 0, no fifo_en.
- Full load, DIM=DEPTH=8, in_valid constant, in_data=k → 64 fifo_en pulses, lane = k/8, done pulses once in cycle after 64th handshake.
- Bubbles: in_valid toggled pseudo-randomly → fifo_en only in cycles following handshakes, word order preserved, done after exactly 64 handshakes.
- Reset mid-load after 20 words, then fresh start → counters restart; first new word goes to FIFO 0.
- start while busy and in_valid while IDLE → no effect; word count and lane mapping unchanged.
- With FIFO_LOADER_ZERO_FLUSH_EN: start → 8 cycles fifo_en=8'hFF, fifo_d=0, in_ready=0, then LOAD as above.
